// File: rtl/sparc_ram_responder_if.sv
// Request/complete bus between the control unit (master) and the RAM responder (slave).
// RAM_enable is a level-held request; MFC answers it and stays high until RAM_enable is withdrawn.
interface sparc_ram_responder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  RAM_enable;
    logic [5:0]            RAM_OpCode;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic [31:0]           data_out;
    logic                  MFC;
    logic                  mem_exc;
    logic [1:0]            fsm_state;

    modport master (
        output RAM_enable, RAM_OpCode, address, data_in,
        input  data_out, MFC, mem_exc, fsm_state
    );

    modport slave (
        input  RAM_enable, RAM_OpCode, address, data_in,
        output data_out, MFC, mem_exc, fsm_state
    );
endinterface

// File: rtl/sparc_ram_responder.sv
// Memory-side responder: latches a load/store request, waits WAIT_STATES cycles, performs a
// big-endian byte/halfword/word access on an internal byte array and raises MFC until released.
module sparc_ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input logic                  clk,
    input logic                  reset,
    sparc_ram_responder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [5:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;
    logic [31:0]           dout_q;
    logic                  mfc_q;
    logic                  exc_q;

    logic [7:0] mem [DEPTH];

    logic                  is_load, is_store, sext, op_ok, fault, complete;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           load_val;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sext     = 1'b0;
        op_ok    = 1'b1;
        size     = SZ_WORD;
        case (op_q)
            6'b000000: begin is_load  = 1'b1; size = SZ_WORD; end
            6'b000001: begin is_load  = 1'b1; size = SZ_BYTE; end
            6'b000010: begin is_load  = 1'b1; size = SZ_HALF; end
            6'b001001: begin is_load  = 1'b1; size = SZ_BYTE; sext = 1'b1; end
            6'b001010: begin is_load  = 1'b1; size = SZ_HALF; sext = 1'b1; end
            6'b000100: begin is_store = 1'b1; size = SZ_WORD; end
            6'b000101: begin is_store = 1'b1; size = SZ_BYTE; end
            6'b000110: begin is_store = 1'b1; size = SZ_HALF; end
            default:   op_ok = 1'b0;
        endcase
    end

    assign fault = !op_ok
                 || (size == SZ_WORD && addr_q[1:0] != 2'b00)
                 || (size == SZ_HALF && addr_q[0]);

    // Completion is the BUSY edge with an exhausted counter and the request still held.
    assign complete = (state == S_BUSY) && bus.RAM_enable && (cnt == 4'd0);

    // Aligned accesses never cross the array top, so OR-ing the low bits cannot wrap.
    assign a1 = addr_q | ADDR_WIDTH'(1);
    assign a2 = addr_q | ADDR_WIDTH'(2);
    assign a3 = addr_q | ADDR_WIDTH'(3);
    assign b0 = mem[addr_q];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        load_val = {24'h0, b0};
        case (size)
            SZ_WORD: load_val = {b0, b1, b2, b3};
            SZ_HALF: load_val = sext ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
            default: load_val = sext ? {{24{b0[7]}}, b0} : {24'h0, b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (complete && is_store && !fault) begin
            case (size)
                SZ_WORD: begin
                    mem[addr_q] <= din_q[31:24];
                    mem[a1]     <= din_q[23:16];
                    mem[a2]     <= din_q[15:8];
                    mem[a3]     <= din_q[7:0];
                end
                SZ_HALF: begin
                    mem[addr_q] <= din_q[15:8];
                    mem[a1]     <= din_q[7:0];
                end
                default: mem[addr_q] <= din_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            op_q   <= 6'd0;
            addr_q <= '0;
            din_q  <= 32'd0;
            dout_q <= 32'd0;
            mfc_q  <= 1'b0;
            exc_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.RAM_enable) begin
                        op_q   <= bus.RAM_OpCode;
                        addr_q <= bus.address;
                        din_q  <= bus.data_in;
                        cnt    <= 4'(WAIT_STATES);
                        state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!bus.RAM_enable) begin
                        state <= S_IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state <= S_DONE;
                        mfc_q <= 1'b1;
                        exc_q <= fault;
                        if (is_load && !fault) dout_q <= load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!bus.RAM_enable) begin
                        state <= S_IDLE;
                        mfc_q <= 1'b0;
                        exc_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out  = dout_q;
    assign bus.MFC       = mfc_q;
    assign bus.mem_exc   = exc_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_sparc_ram_responder.sv
// Bench for sparc_ram_responder: table of directed vectors, handshake corner sequences, and
// random accesses scored against a byte-array reference model.
module tb_sparc_ram_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sparc_ram_responder_if #(.ADDR_WIDTH(9)) bus2 ();
    sparc_ram_responder_if #(.ADDR_WIDTH(9)) bus0 ();

    sparc_ram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );
    sparc_ram_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );

    typedef struct {
        logic [5:0]  op;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_exc;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] exp_q[$];
    logic [7:0]  ref_mem[512];
    logic [31:0] ref_dout;
    int          n_pass;
    int          n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input bit sel, input logic en, input logic [5:0] op,
                         input logic [8:0] a, input logic [31:0] d);
        if (sel) begin
            bus0.RAM_enable = en; bus0.RAM_OpCode = op; bus0.address = a; bus0.data_in = d;
        end else begin
            bus2.RAM_enable = en; bus2.RAM_OpCode = op; bus2.address = a; bus2.data_in = d;
        end
    endtask

    function automatic logic mfc_of(input bit sel);
        return sel ? bus0.MFC : bus2.MFC;
    endfunction

    // One full handshake; inputs are scrambled right after the request is sampled.
    task automatic access(input bit sel, input logic [5:0] op, input logic [8:0] a,
                          input logic [31:0] d, output logic [31:0] dout,
                          output logic exc, output int lat);
        @(negedge clk);
        drive(sel, 1'b1, op, a, d);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(sel, 1'b1, 6'h3F, ~a, ~d);
            if (mfc_of(sel)) begin
                lat = i;
                break;
            end
        end
        dout = sel ? bus0.data_out : bus2.data_out;
        exc  = sel ? bus0.mem_exc  : bus2.mem_exc;
        @(negedge clk);
        drive(sel, 1'b0, 6'h0, 9'h0, 32'h0);
        @(posedge clk); #1;
        check("mfc_drop", {31'h0, mfc_of(sel)}, 32'h0);
    endtask

    // Reference model: computes each access from the opcode rules on a plain byte array.
    task automatic model_step(input logic [5:0] op, input logic [8:0] a, input logic [31:0] d);
        int n; bit ld; bit sx; bit ok;
        logic [31:0] v;
        n = 1; ld = 0; sx = 0; ok = 1;
        case (op)
            6'h00: begin n = 4; ld = 1; end
            6'h01: begin n = 1; ld = 1; end
            6'h02: begin n = 2; ld = 1; end
            6'h09: begin n = 1; ld = 1; sx = 1; end
            6'h0A: begin n = 2; ld = 1; sx = 1; end
            6'h04: n = 4;
            6'h05: n = 1;
            6'h06: n = 2;
            default: ok = 0;
        endcase
        if (ok && (int'(a) % n) != 0) ok = 0;
        if (!ok) begin
            exp_q.push_back({1'b1, ref_dout});
        end else if (ld) begin
            v = 32'h0;
            for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[int'(a) + k]);
            if (sx && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            ref_dout = v;
            exp_q.push_back({1'b0, v});
        end else begin
            for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = 8'(d >> (8 * (n - 1 - k)));
            exp_q.push_back({1'b0, ref_dout});
        end
    endtask

    initial begin
        logic [31:0] dout;
        logic        exc;
        int          lat;
        logic [32:0] exp;
        logic [5:0]  op_tab[9];
        logic [5:0]  op;
        logic [8:0]  a;
        logic [31:0] d;
        int          hi_cnt;
        int          lo_cnt;

        n_pass = 0; n_total = 0; ref_dout = 32'h0;
        op_tab = '{6'h00, 6'h01, 6'h02, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h06, 6'h3F};
        reset = 1'b1;
        drive(0, 1'b0, 6'h0, 9'h0, 32'h0);
        drive(1, 1'b0, 6'h0, 9'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mfc",   {31'h0, bus2.MFC}, 32'h0);
        check("rst_exc",   {31'h0, bus2.mem_exc}, 32'h0);
        check("rst_dout",  bus2.data_out, 32'h0);
        check("rst_state", {30'h0, bus2.fsm_state}, 32'h0);

        vecs.push_back('{6'h04, 9'h010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{6'h00, 9'h010, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{6'h01, 9'h010, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{6'h09, 9'h010, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{6'h02, 9'h012, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{6'h0A, 9'h012, 32'h0,        32'hFFFFBEEF, 1'b0});
        vecs.push_back('{6'h05, 9'h013, 32'h00000011, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{6'h06, 9'h010, 32'h00002233, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{6'h00, 9'h010, 32'h0,        32'h2233BE11, 1'b0});
        vecs.push_back('{6'h00, 9'h011, 32'h0,        32'h2233BE11, 1'b1});
        vecs.push_back('{6'h06, 9'h013, 32'h00009999, 32'h2233BE11, 1'b1});
        vecs.push_back('{6'h3F, 9'h010, 32'h12345678, 32'h2233BE11, 1'b1});
        vecs.push_back('{6'h00, 9'h010, 32'h0,        32'h2233BE11, 1'b0});
        vecs.push_back('{6'h05, 9'h012, 32'hFFFFFF77, 32'h2233BE11, 1'b0});
        vecs.push_back('{6'h00, 9'h010, 32'h0,        32'h22337711, 1'b0});
        vecs.push_back('{6'h04, 9'h020, 32'h11223344, 32'h22337711, 1'b0});
        vecs.push_back('{6'h04, 9'h1FC, 32'h0BADCAFE, 32'h22337711, 1'b0});
        vecs.push_back('{6'h00, 9'h1FC, 32'h0,        32'h0BADCAFE, 1'b0});
        vecs.push_back('{6'h09, 9'h1FF, 32'h0,        32'hFFFFFFFE, 1'b0});
        vecs.push_back('{6'h01, 9'h1FD, 32'h0,        32'h000000AD, 1'b0});

        foreach (vecs[i]) begin
            model_step(vecs[i].op, vecs[i].addr, vecs[i].din);
            exp = exp_q.pop_front();
            access(0, vecs[i].op, vecs[i].addr, vecs[i].din, dout, exc, lat);
            check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_exc", i), {31'h0, exc}, {31'h0, vecs[i].exp_exc});
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
        end

        // Request held through DONE for five cycles: one completion, no restart.
        model_step(6'h00, 9'h010, 32'h0);
        exp = exp_q.pop_front();
        @(negedge clk); drive(0, 1'b1, 6'h00, 9'h010, 32'h0);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus2.MFC) begin lat = i; break; end
        end
        check("hold_lat", 32'(lat), 32'd3);
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus2.MFC) hi_cnt++;
        end
        check("hold_mfc_cycles", 32'(hi_cnt), 32'd5);
        check("hold_dout", bus2.data_out, exp[31:0]);
        @(negedge clk); drive(0, 1'b0, 6'h0, 9'h0, 32'h0);
        lo_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus2.MFC) lo_cnt++;
        end
        check("hold_no_second", 32'(lo_cnt), 32'd0);

        // Request withdrawn while BUSY: no write, MFC never rises.
        @(negedge clk); drive(0, 1'b1, 6'h04, 9'h010, 32'h55555555);
        @(posedge clk); @(posedge clk); #1;
        check("abort_busy", {30'h0, bus2.fsm_state}, 32'd1);
        @(negedge clk); drive(0, 1'b0, 6'h0, 9'h0, 32'h0);
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus2.MFC) hi_cnt++;
        end
        check("abort_mfc", 32'(hi_cnt), 32'd0);
        check("abort_dout", bus2.data_out, ref_dout);
        model_step(6'h00, 9'h010, 32'h0);
        exp = exp_q.pop_front();
        access(0, 6'h00, 9'h010, 32'h0, dout, exc, lat);
        check("abort_mem", dout, 32'h22337711);

        // Zero wait states: completion one edge after the request.
        access(1, 6'h04, 9'h040, 32'hA5A5A5A5, dout, exc, lat);
        check("w0_st_lat", 32'(lat), 32'd1);
        check("w0_st_exc", {31'h0, exc}, 32'h0);
        access(1, 6'h00, 9'h040, 32'h0, dout, exc, lat);
        check("w0_ld_lat", 32'(lat), 32'd1);
        check("w0_ld_dout", dout, 32'hA5A5A5A5);
        access(1, 6'h02, 9'h041, 32'h0, dout, exc, lat);
        check("w0_fault_exc", {31'h0, exc}, 32'h1);
        check("w0_fault_dout", dout, 32'hA5A5A5A5);

        // Fill the random region so every model byte is defined.
        for (int w = 9'h100; w < 9'h200; w += 4) begin
            d = $urandom;
            model_step(6'h04, 9'(w), d);
            exp = exp_q.pop_front();
            access(0, 6'h04, 9'(w), d, dout, exc, lat);
            check("fill_exc", {31'h0, exc}, 32'h0);
        end

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 9) op = 6'($urandom_range(0, 63));
            else op = op_tab[$urandom_range(0, 8)];
            a = 9'h100 + 9'($urandom_range(0, 255));
            d = $urandom;
            model_step(op, a, d);
            access(0, op, a, d, dout, exc, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd%0d_op%h_a%h_dout", i, op, a), dout, exp[31:0]);
            check($sformatf("rnd%0d_exc", i), {31'h0, exc}, {31'h0, exp[32]});
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
        end

        // Reset pulsed while BUSY with a store to 0x020.
        @(negedge clk); drive(0, 1'b1, 6'h04, 9'h020, 32'hCAFEF00D);
        @(posedge clk); @(posedge clk); #1;
        check("rst_mid_busy", {30'h0, bus2.fsm_state}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_mfc",   {31'h0, bus2.MFC}, 32'h0);
        check("rst_mid_exc",   {31'h0, bus2.mem_exc}, 32'h0);
        check("rst_mid_dout",  bus2.data_out, 32'h0);
        check("rst_mid_state", {30'h0, bus2.fsm_state}, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 6'h0, 9'h0, 32'h0);
        reset = 1'b0;
        ref_dout = 32'h0;
        model_step(6'h00, 9'h020, 32'h0);
        exp = exp_q.pop_front();
        access(0, 6'h00, 9'h020, 32'h0, dout, exc, lat);
        check("rst_mem_kept", dout, 32'h11223344);
        check("rst_mem_lat", 32'(lat), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
